// File: rtl/sdspi_block_emulator_pkg.sv
// rtl/sdspi_block_emulator_pkg.sv - shared types and constants for the SD-SPI block emulator
package sdspi_block_emulator_pkg;

    localparam int SD_BLOCK_BYTES = 512;
    localparam int SD_WR_TRAILER  = 4;
    localparam int PTR_W          = 10;

    typedef enum logic [2:0] {
        IDLE,
        RST_BUSY,
        OPEN_BUSY,
        RD_READY,
        RD_BYTE_BUSY,
        WR_READY,
        WR_BYTE_BUSY,
        ERR
    } emu_state_t;

endpackage

// File: rtl/sdspi_block_emulator_ram.sv
// rtl/sdspi_block_emulator_ram.sv - single-port byte RAM, synchronous read with one cycle latency
module sd_block_ram #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        wdata_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/sdspi_block_emulator.sv
// rtl/sdspi_block_emulator.sv - RAM-backed responder for the SD-SPI host block command handshake
module sdspi_block_emulator
    import sdspi_block_emulator_pkg::*;
#(
    parameter int          NUM_BLOCKS  = 4,
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int          INIT_CYCLES = 16,
    parameter int          OPEN_CYCLES = 8,
    parameter int          BYTE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_rst_i,
    input  logic [31:0] spi_block_addr_i,
    input  logic        spi_r_block_i,
    input  logic        spi_r_byte_i,
    input  logic        spi_r_multi_block_i,
    input  logic        spi_w_block_i,
    input  logic        spi_w_byte_i,
    input  logic [7:0]  spi_data_in_i,
    output logic        spi_busy_o,
    output logic [7:0]  spi_data_out_o,
    output logic        spi_err_o,
    output logic        spi_crc_err_o
);

    localparam int BLK_W  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int DLY_W  = 16;
    localparam logic [PTR_W-1:0] PTR_END = PTR_W'(SD_BLOCK_BYTES);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(SD_BLOCK_BYTES + SD_WR_TRAILER);

    emu_state_t       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             err_q, err_d;
    logic             mode_rd_q, mode_rd_d;
    logic             rd_arm_q, wr_arm_q;
    logic             rd_start, wr_start;
    logic [31:0]      blk_off;
    logic             ram_we;
    logic [BLK_W+8:0] ram_addr;
    logic [7:0]       ram_rdata;
    logic             unused_inputs;

    assign blk_off       = spi_block_addr_i - BASE_ADDR;
    assign unused_inputs = spi_r_multi_block_i;

    always_comb begin
        state_d    = state_q;
        dly_d      = dly_q;
        ptr_d      = ptr_q;
        blk_d      = blk_q;
        data_out_d = data_out_q;
        err_d      = err_q;
        mode_rd_d  = mode_rd_q;
        ram_we     = 1'b0;
        ram_addr   = {blk_q, ptr_q[8:0]};
        rd_start   = 1'b0;
        wr_start   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (spi_rst_i) begin
                    state_d = RST_BUSY;
                    dly_d   = DLY_W'(INIT_CYCLES - 1);
                    err_d   = 1'b0;
                end else if (spi_r_block_i || spi_w_block_i) begin
                    mode_rd_d = spi_r_block_i;
                    blk_d     = blk_off[BLK_W-1:0];
                    ptr_d     = '0;
                    if (blk_off >= 32'(NUM_BLOCKS)) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = OPEN_BUSY;
                        dly_d   = DLY_W'(OPEN_CYCLES - 1);
                        err_d   = 1'b0;
                    end
                end
            end
            RST_BUSY: begin
                if (dly_q == '0) state_d = IDLE;
                else             dly_d   = dly_q - 1'b1;
            end
            OPEN_BUSY: begin
                // Byte 0 is read continuously here so it is ready by the last busy cycle.
                if (dly_q == '0) begin
                    if (mode_rd_q) begin
                        state_d    = RD_READY;
                        data_out_d = ram_rdata;
                    end else begin
                        state_d = WR_READY;
                    end
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            RD_READY: begin
                if (!spi_r_block_i) begin
                    state_d = IDLE;
                end else if (spi_r_byte_i && rd_arm_q) begin
                    rd_start = 1'b1;
                    state_d  = RD_BYTE_BUSY;
                    dly_d    = DLY_W'(BYTE_CYCLES - 1);
                    ptr_d    = (ptr_q < PTR_END) ? ptr_q + 1'b1 : ptr_q;
                end
            end
            RD_BYTE_BUSY: begin
                if (dly_q == '0) begin
                    state_d    = RD_READY;
                    data_out_d = (ptr_q < PTR_END) ? ram_rdata : 8'hFF;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            WR_READY: begin
                if (!spi_w_block_i) begin
                    state_d = IDLE;
                end else if (spi_w_byte_i && wr_arm_q) begin
                    wr_start = 1'b1;
                    state_d  = WR_BYTE_BUSY;
                    dly_d    = DLY_W'(BYTE_CYCLES - 1);
                end
            end
            WR_BYTE_BUSY: begin
                // A reset landing on the commit cycle must not reach the RAM.
                if (dly_q == '0) begin
                    ram_we  = (ptr_q < PTR_END) && !rst;
                    ptr_d   = (ptr_q < PTR_MAX) ? ptr_q + 1'b1 : ptr_q;
                    state_d = WR_READY;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ERR: begin
                if (!spi_r_block_i && !spi_w_block_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            ptr_q      <= '0;
            blk_q      <= '0;
            data_out_q <= 8'hFF;
            err_q      <= 1'b0;
            mode_rd_q  <= 1'b0;
            rd_arm_q   <= 1'b1;
            wr_arm_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            dly_q      <= dly_d;
            ptr_q      <= ptr_d;
            blk_q      <= blk_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
            mode_rd_q  <= mode_rd_d;
            // A held byte request only re-arms after it has been seen low.
            rd_arm_q   <= !spi_r_byte_i ? 1'b1 : (rd_start ? 1'b0 : rd_arm_q);
            wr_arm_q   <= !spi_w_byte_i ? 1'b1 : (wr_start ? 1'b0 : wr_arm_q);
        end
    end

    sd_block_ram #(
        .ADDR_W (BLK_W + 9)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (spi_data_in_i),
        .rdata_o (ram_rdata)
    );

    assign spi_busy_o     = (state_q == RST_BUSY) || (state_q == OPEN_BUSY) ||
                            (state_q == RD_BYTE_BUSY) || (state_q == WR_BYTE_BUSY);
    assign spi_data_out_o = data_out_q;
    assign spi_err_o      = err_q;
    assign spi_crc_err_o  = 1'b0;

endmodule
